// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, functs, ALU codes,
// FSM states and datapath mux selects.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_IDLE  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_EX_LS  = 4'd4,
    S_EX_BR  = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_LW  = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps an operation class plus R-type funct to an
// ALU code, and flags functs the ALU does not implement.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [5:0]            funct,
  input  alu_op_e               alu_op,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  funct_ok
);

  logic [3:0] fcode;

  // Kept separate from the class mux so funct_ok never depends on alu_op.
  always_comb begin
    fcode    = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  fcode = ALU_ADD;
      FN_SUB:  fcode = ALU_SUB;
      FN_AND:  fcode = ALU_AND;
      FN_OR:   fcode = ALU_OR;
      FN_SLT:  fcode = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = '1;
    case (alu_op)
      AOP_ADD:   alu_ctrl = ALU_CTRL_W'(ALU_ADD);
      AOP_SUB:   alu_ctrl = ALU_CTRL_W'(ALU_SUB);
      AOP_FUNCT: alu_ctrl = ALU_CTRL_W'(fcode);
      default:   alu_ctrl = '1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back,
// with a memory ready handshake, wait timeout and illegal-op detection.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int WAIT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  ext_sel,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [3:0]            state
);

  // Last counter value before the wait that would reach 2^WAIT_W-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((1 << WAIT_W) - 2);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q, bus_err_d;
  alu_op_e             alu_op;
  logic                funct_ok;
  logic                mem_access, timeout;
  logic                mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .funct    (funct),
    .alu_op   (alu_op),
    .alu_ctrl (alu_ctrl),
    .funct_ok (funct_ok)
  );

  assign mem_access = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout    = mem_access && !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    i_or_d      = 1'b0;
    pc_src      = PC_PLUS4;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    ext_sel     = 1'b0;
    alu_op      = AOP_IDLE;
    case (state_q)
      S_IF: begin
        mem_req_c = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = AOP_ADD;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = AOP_ADD;
        ext_sel   = 1'b1;
        state_d   = S_IF;
        case (op)
          OP_RTYPE:     if (funct_ok) state_d = S_EX_R; else illegal_c = 1'b1;
          OP_LW, OP_SW: state_d = S_EX_LS;
          OP_ADDI:      state_d = S_EX_I;
          OP_BEQ, OP_BNE: state_d = S_EX_BR;
          OP_J: begin
            pc_write_c = 1'b1;
            pc_src     = PC_JUMP;
          end
          default:      illegal_c = 1'b1;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_FUNCT;
        state_d   = S_WB_R;
      end
      S_EX_I, S_EX_LS: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_sel   = 1'b1;
        alu_op    = AOP_ADD;
        if (state_q == S_EX_I)  state_d = S_WB_I;
        else if (op == OP_LW)   state_d = S_MEM_RD;
        else                    state_d = S_MEM_WR;
      end
      S_EX_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = AOP_SUB;
        pc_src     = PC_BRANCH;
        pc_write_c = (op == OP_BNE) ? !zero : zero;
        state_d    = S_IF;
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_req_c   = 1'b1;
        mem_write_c = (state_q == S_MEM_WR);
        i_or_d      = 1'b1;
        if (mem_ready)    state_d = (state_q == S_MEM_RD) ? S_WB_LW : S_IF;
        else if (timeout) state_d = S_IF;
      end
      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_IF;
      end
      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_IF;
      end
      S_WB_LW: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    wait_d    = wait_q;
    bus_err_d = bus_err_q | timeout;
    if (timeout || (state_d != state_q)) wait_d = '0;
    else if (mem_access && !mem_ready)   wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Strobes are forced low for the whole reset pulse, not just after an edge.
  assign mem_req   = mem_req_c   & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_write  = pc_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;
  assign illegal   = illegal_c   & ~rst;
  assign bus_err   = bus_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default instance and a WAIT_W=2
// instance run side by side; the second one exercises the memory timeout.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst, rst_t, zero, mem_ready;
  logic [5:0] op, funct;

  logic       mem_req, mem_write, i_or_d, ir_write, pc_write, reg_dst, reg_write;
  logic       mem_to_reg, alu_src_a, ext_sel, illegal, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl, state;

  logic       t_mem_req, t_mem_write, t_i_or_d, t_ir_write, t_pc_write, t_reg_dst, t_reg_write;
  logic       t_mem_to_reg, t_alu_src_a, t_ext_sel, t_illegal, t_bus_err;
  logic [1:0] t_pc_src, t_alu_src_b;
  logic [3:0] t_alu_ctrl, t_state;

  logic [5:0] strb, t_strb;
  assign strb   = {mem_req, mem_write, ir_write, pc_write, reg_write, illegal};
  assign t_strb = {t_mem_req, t_mem_write, t_ir_write, t_pc_write, t_reg_write, t_illegal};

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .alu_ctrl(alu_ctrl), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  multicycle_control #(.ALU_CTRL_W(4), .WAIT_W(2)) dut_t (
    .clk(clk), .rst(rst_t), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(t_mem_req), .mem_write(t_mem_write), .i_or_d(t_i_or_d), .ir_write(t_ir_write),
    .pc_write(t_pc_write), .pc_src(t_pc_src), .reg_dst(t_reg_dst), .reg_write(t_reg_write),
    .mem_to_reg(t_mem_to_reg), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
    .ext_sel(t_ext_sel), .alu_ctrl(t_alu_ctrl), .illegal(t_illegal), .bus_err(t_bus_err),
    .state(t_state)
  );

  task automatic test_reset();
    #2;
    tests_run++;
    if (state !== 4'd0 || t_state !== 4'd0) begin
      tests_failed++; $display("FAIL reset_state: got %0d/%0d want 0", state, t_state);
    end
    tests_run++;
    if (strb !== 6'b0 || t_strb !== 6'b0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b/%b want 000000", strb, t_strb);
    end
    tests_run++;
    if (bus_err !== 1'b0 || t_bus_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_bus_err: got %b/%b want 0", bus_err, t_bus_err);
    end
    @(negedge clk);
    rst = 1'b0; rst_t = 1'b0;
    #1;
    tests_run++;
    if (state !== 4'd0 || mem_req !== 1'b1) begin
      tests_failed++; $display("FAIL release_if: state %0d mem_req %b want 0/1", state, mem_req);
    end
  endtask

  task automatic test_add();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd0};
    logic [5:0] ex [5] = '{6'b101100, 6'b000000, 6'b000000, 6'b000010, 6'b101100};
    op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (state !== es[i] || t_state !== es[i]) begin
        tests_failed++; $display("FAIL add_state[%0d]: got %0d/%0d want %0d", i, state, t_state, es[i]);
      end
      tests_run++;
      if (strb !== ex[i] || t_strb !== ex[i]) begin
        tests_failed++; $display("FAIL add_strobes[%0d]: got %b/%b want %b", i, strb, t_strb, ex[i]);
      end
      if (i == 0) begin
        tests_run++;
        if ({i_or_d, alu_src_a, alu_src_b, pc_src, alu_ctrl} !== 10'b0_0_01_00_0010) begin
          tests_failed++; $display("FAIL add_if_fields: got %b want 0001000010",
                                   {i_or_d, alu_src_a, alu_src_b, pc_src, alu_ctrl});
        end
      end
      if (i == 1) begin
        tests_run++;
        if ({alu_src_a, alu_src_b, ext_sel, alu_ctrl} !== 8'b0_11_1_0010) begin
          tests_failed++; $display("FAIL add_id_fields: got %b want 01110010",
                                   {alu_src_a, alu_src_b, ext_sel, alu_ctrl});
        end
      end
      if (i == 2) begin
        tests_run++;
        if ({alu_src_a, alu_src_b, alu_ctrl} !== 7'b1_00_0010) begin
          tests_failed++; $display("FAIL add_ex_fields: got %b want 1000010",
                                   {alu_src_a, alu_src_b, alu_ctrl});
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({reg_dst, mem_to_reg} !== 2'b10) begin
          tests_failed++; $display("FAIL add_wb_fields: got %b want 10", {reg_dst, mem_to_reg});
        end
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_rtype();
    logic [5:0] fn [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000};
    logic [3:0] ac [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010};
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd8};
    op = 6'b000000; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      funct = fn[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        tests_run++;
        if (state !== es[i] || t_state !== es[i]) begin
          tests_failed++; $display("FAIL rtype%0d_state[%0d]: got %0d/%0d want %0d", k, i, state, t_state, es[i]);
        end
        if (i == 2) begin
          tests_run++;
          if (alu_ctrl !== ac[k] || t_alu_ctrl !== ac[k]) begin
            tests_failed++; $display("FAIL rtype%0d_alu_ctrl: got %b/%b want %b", k, alu_ctrl, t_alu_ctrl, ac[k]);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] es [8] = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd6, 4'd6, 4'd10, 4'd0};
    logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [5:0] ex [8] = '{6'b101100, 6'b0, 6'b0, 6'b100000, 6'b100000, 6'b100000, 6'b000010, 6'b101100};
    op = 6'b100011; funct = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      #1;
      tests_run++;
      if (state !== es[i] || t_state !== es[i]) begin
        tests_failed++; $display("FAIL lw_state[%0d]: got %0d/%0d want %0d", i, state, t_state, es[i]);
      end
      tests_run++;
      if (strb !== ex[i] || t_strb !== ex[i]) begin
        tests_failed++; $display("FAIL lw_strobes[%0d]: got %b/%b want %b", i, strb, t_strb, ex[i]);
      end
      if (i == 2) begin
        tests_run++;
        if ({alu_src_a, alu_src_b, ext_sel, alu_ctrl} !== 8'b1_10_1_0010) begin
          tests_failed++; $display("FAIL lw_ex_fields: got %b want 11010010",
                                   {alu_src_a, alu_src_b, ext_sel, alu_ctrl});
        end
      end
      if (i == 3) begin
        tests_run++;
        if (i_or_d !== 1'b1) begin
          tests_failed++; $display("FAIL lw_i_or_d: got %b want 1", i_or_d);
        end
      end
      if (i == 6) begin
        tests_run++;
        if ({reg_dst, mem_to_reg} !== 2'b01) begin
          tests_failed++; $display("FAIL lw_wb_fields: got %b want 01", {reg_dst, mem_to_reg});
        end
      end
      if (i < 7) @(negedge clk);
    end
  endtask

  task automatic test_addi_sw();
    logic [5:0] ops [2] = '{6'b001000, 6'b101011};
    logic [3:0] es [2][4] = '{'{4'd0, 4'd1, 4'd3, 4'd9}, '{4'd0, 4'd1, 4'd4, 4'd7}};
    logic [5:0] ex [2][4] = '{'{6'b101100, 6'b0, 6'b0, 6'b000010},
                              '{6'b101100, 6'b0, 6'b0, 6'b110000}};
    mem_ready = 1'b1; funct = 6'b000000;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        tests_run++;
        if (state !== es[k][i] || t_state !== es[k][i]) begin
          tests_failed++; $display("FAIL op%0d_state[%0d]: got %0d/%0d want %0d", k, i, state, t_state, es[k][i]);
        end
        tests_run++;
        if (strb !== ex[k][i] || t_strb !== ex[k][i]) begin
          tests_failed++; $display("FAIL op%0d_strobes[%0d]: got %b/%b want %b", k, i, strb, t_strb, ex[k][i]);
        end
        if (k == 0 && i == 3) begin
          tests_run++;
          if ({reg_dst, mem_to_reg} !== 2'b00) begin
            tests_failed++; $display("FAIL addi_wb_fields: got %b want 00", {reg_dst, mem_to_reg});
          end
        end
        if (k == 1 && i == 3) begin
          tests_run++;
          if (i_or_d !== 1'b1) begin
            tests_failed++; $display("FAIL sw_i_or_d: got %b want 1", i_or_d);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branches();
    logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pw  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] es  [3] = '{4'd0, 4'd1, 4'd5};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = ops[k]; zero = zs[k];
      for (int i = 0; i < 3; i++) begin
        #1;
        tests_run++;
        if (state !== es[i] || t_state !== es[i]) begin
          tests_failed++; $display("FAIL br%0d_state[%0d]: got %0d/%0d want %0d", k, i, state, t_state, es[i]);
        end
        if (i == 2) begin
          tests_run++;
          if ({pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl} !== {pw[k], 9'b01_1_00_0110}) begin
            tests_failed++; $display("FAIL br%0d_fields: got %b want %b", k,
                                     {pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl}, {pw[k], 9'b01_1_00_0110});
          end
        end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    op = 6'b000010; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 4'd1 || strb !== 6'b000100 || pc_src !== 2'b10) begin
      tests_failed++; $display("FAIL jump_id: state %0d strobes %b pc_src %b want 1/000100/10", state, strb, pc_src);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 4'd0 || t_state !== 4'd0) begin
      tests_failed++; $display("FAIL jump_done: got %0d/%0d want 0", state, t_state);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'b111111, 6'b000000};
    mem_ready = 1'b1; funct = 6'b000000;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      @(negedge clk);
      #1;
      tests_run++;
      if (state !== 4'd1 || strb !== 6'b000001 || t_strb !== 6'b000001) begin
        tests_failed++; $display("FAIL illegal%0d_id: state %0d strobes %b/%b want 1/000001", k, state, strb, t_strb);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (state !== 4'd0 || illegal !== 1'b0) begin
        tests_failed++; $display("FAIL illegal%0d_after: state %0d illegal %b want 0/0", k, state, illegal);
      end
    end
  endtask

  task automatic test_timeout_and_reset();
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd7, 4'd7};
    logic       rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ea [5] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd0};
    op = 6'b101011; funct = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rd[i];
      #1;
      tests_run++;
      if (state !== es[i] || t_state !== es[i]) begin
        tests_failed++; $display("FAIL sw_to_state[%0d]: got %0d/%0d want %0d", i, state, t_state, es[i]);
      end
      if (i == 5) begin
        tests_run++;
        if (t_bus_err !== 1'b0) begin
          tests_failed++; $display("FAIL bus_err_early: got %b want 0", t_bus_err);
        end
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (t_state !== 4'd0 || t_bus_err !== 1'b1) begin
      tests_failed++; $display("FAIL timeout: state %0d bus_err %b want 0/1", t_state, t_bus_err);
    end
    tests_run++;
    if (state !== 4'd7 || {mem_req, mem_write} !== 2'b11 || bus_err !== 1'b0) begin
      tests_failed++; $display("FAIL no_timeout_default: state %0d req/wr %b bus_err %b want 7/11/0",
                               state, {mem_req, mem_write}, bus_err);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (strb !== 6'b0 || state !== 4'd0) begin
      tests_failed++; $display("FAIL async_reset: strobes %b state %0d want 000000/0", strb, state);
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; op = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (state !== ea[i] || t_state !== ea[i]) begin
        tests_failed++; $display("FAIL post_reset_state[%0d]: got %0d/%0d want %0d", i, state, t_state, ea[i]);
      end
      if (i < 4) @(negedge clk);
    end
    tests_run++;
    if (t_bus_err !== 1'b1 || bus_err !== 1'b0) begin
      tests_failed++; $display("FAIL bus_err_sticky: got %b/%b want 0/1", bus_err, t_bus_err);
    end
  endtask

  initial begin
    rst = 1'b1; rst_t = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    op = 6'b000000; funct = 6'b100000;
    test_reset();
    test_add();
    test_back_to_back_rtype();
    test_lw_wait();
    test_addi_sw();
    test_branches();
    test_jump();
    test_illegal();
    test_timeout_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
